// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: op and state encodings,
// address helpers and the data-memory base address.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_e;

    localparam logic [31:0] DRAM_BASE = 32'h1001_0000;

    function automatic logic is_load(op_e op);
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Byte ops can never be misaligned.
    function automatic logic is_misaligned(op_e op, logic [1:0] a);
        case (op)
            OP_LW, OP_SW:         return (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: return a[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Clears the address bits below the natural alignment of the op.
    function automatic logic [31:0] align_addr(op_e op, logic [31:0] a);
        case (op)
            OP_LW, OP_SW:         return {a[31:2], 2'b00};
            OP_LH, OP_LHU, OP_SH: return {a[31:1], 1'b0};
            default:              return a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: picks the byte/halfword lane out of a memory
// word and extends it for loads, and splices store data into the word for
// sub-word read-modify-write.
module lsu_lane_unit
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  op_e         op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]  blane;
    logic        hlane;
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  bval;
    logic [15:0] hval;

    // Lane selection, load extension and store merge.
    always_comb begin
        blane = BIG_ENDIAN ? ~byte_sel : byte_sel;
        hlane = BIG_ENDIAN ? ~byte_sel[1] : byte_sel[1];
        bsh   = {blane, 3'b000};
        hsh   = {hlane, 4'b0000};
        bval  = 8'(word >> bsh);
        hval  = 16'(word >> hsh);

        load_data = word;
        case (op)
            OP_LB:   load_data = {{24{bval[7]}}, bval};
            OP_LBU:  load_data = {24'h0, bval};
            OP_LH:   load_data = {{16{hval[15]}}, hval};
            OP_LHU:  load_data = {16'h0, hval};
            default: load_data = word;
        endcase

        merged = word;
        case (op)
            OP_SB:   merged = (word & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata[7:0]} << bsh);
            OP_SH:   merged = (word & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata} << hsh);
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// One request in flight; sub-word stores are done as read-modify-write.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; req_ready high
//   RD    | word read from memory, captured into word_q at the end
//   WR    | word write (full store or merged sub-word store)
//   DONE  | completion pulse; load result presented on rdata
//   ABORT | misaligned access rejected, done+err, no memory cycle
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN      = 1'b0,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q;
    state_e      state_d;
    op_e         op_q;
    op_e         req_op_e;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_op_e = op_e'(req_op);

    lsu_lane_unit #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .op        (op_q),
        .byte_sel  (addr_q[1:0]),
        .word      (word_q),
        .wdata     (wdata_q[15:0]),
        .load_data (load_ext),
        .merged    (merged)
    );

    // Memory side is driven only from state and latched registers.
    assign mem_addr = {addr_q[31:2], 2'b00};

    // The load result is visible during the DONE pulse and held afterwards.
    assign rdata = (state_q == DONE && is_load(op_q)) ? load_ext : rdata_q;

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (ERR_ON_MISALIGN && is_misaligned(req_op_e, req_addr[1:0]))
                        state_d = ABORT;
                    else if (req_op_e == OP_SW)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                mem_ena = 1'b1;
                state_d = is_load(op_q) ? DONE : WR;
            end
            WR: begin
                mem_wena  = 1'b1;
                mem_wdata = (op_q == OP_SW) ? wdata_q : merged;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op_e;
                // Aligned requests are unchanged; misaligned ones either abort
                // or proceed with the low bits forced to alignment.
                addr_q  <= align_addr(req_op_e, req_addr);
                wdata_q <= req_wdata;
            end
            if (state_q == RD)
                word_q <= mem_rdata;
            if (state_q == DONE && is_load(op_q))
                rdata_q <= load_ext;
        end
    end

endmodule
